// File: rtl/clb_cfg_pkg.sv
// Purpose: shared types and constants for the CLB slice configuration loader.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package clb_cfg_pkg;

  // Loader frame states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_SHIFT,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  // Frame start marker
  localparam logic [7:0] CFG_SYNC_WORD = 8'hA5;

  // Slice geometry that sets the chain length
  localparam int NUM_LUTS  = 4;
  localparam int S_XX_BASE = 5;
  localparam int MUX_LVLS  = 2;

  // Each LUT holds a 2^S_XX_BASE truth table plus two mode bits.
  // The chain also holds one bit per output mux level and one use_cc bit.
  function automatic int calc_chain_len(input int num_luts,
                                        input int s_xx_base,
                                        input int mux_lvls);
    return num_luts * ((1 << s_xx_base) + 2) + mux_lvls + 1;
  endfunction

  localparam int CFG_CHAIN_LEN = calc_chain_len(NUM_LUTS, S_XX_BASE, MUX_LVLS);

endpackage

// File: rtl/cfg_word_serializer.sv
// Purpose: loads one bitstream word and shifts up to nbits of it, LSB first, onto the chain.
// Latency: the first bit appears on cen/cfg_bit in the cycle after load.
// Backpressure: the parent may load only when o_empty, or when o_last (gap-free refill).
module cfg_word_serializer #(
  parameter int WORD_W = 8,
  parameter int WB_W   = $clog2(WORD_W + 1)
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic [WB_W-1:0]   i_nbits,
  output logic              o_cen,
  output logic              o_cfg_bit,
  output logic              o_empty,
  output logic              o_last
);

  logic [WORD_W-1:0] r_shreg;
  logic [WB_W-1:0]   r_wbits;
  logic              r_cen;
  logic              r_cfg_bit;
  logic [WORD_W-1:0] w_shreg_nxt;
  logic [WB_W-1:0]   w_wbits_nxt;

  // Next shift-register contents: a load replaces the word (consuming any last bit); otherwise shift out one bit
  always_comb begin
    w_shreg_nxt = r_shreg;
    w_wbits_nxt = r_wbits;
    if (i_load) begin
      w_shreg_nxt = i_word;
      w_wbits_nxt = i_nbits;
    end else if (r_wbits != '0) begin
      w_shreg_nxt = r_shreg >> 1;
      w_wbits_nxt = r_wbits - WB_W'(1);
    end
  end

  // cen/cfg_bit are flops fed from the next-state view, so the slice sees clean registered outputs
  always_ff @(posedge cclk) begin
    if (rst) begin
      r_shreg   <= '0;
      r_wbits   <= '0;
      r_cen     <= 1'b0;
      r_cfg_bit <= 1'b0;
    end else begin
      r_shreg   <= w_shreg_nxt;
      r_wbits   <= w_wbits_nxt;
      r_cen     <= (w_wbits_nxt != '0);
      r_cfg_bit <= (w_wbits_nxt != '0) & w_shreg_nxt[0];
    end
  end

  assign o_cen     = r_cen;
  assign o_cfg_bit = r_cfg_bit;
  assign o_empty   = (r_wbits == '0);
  assign o_last    = (r_wbits == WB_W'(1)) && r_cen;

endmodule

// File: rtl/clb_config_loader.sv
// Purpose: parses sync word and 16-bit length header, then streams the payload bit-serially into a CLB config chain.
// Latency: first cen one cycle after the first payload word; sync word to done is 3 + CHAIN_LEN + 1 cycles.
// Backpressure: s_ready is a function of state only; in SHIFT it reopens on the last bit of a word for gap-free streaming.
module clb_config_loader
  import clb_cfg_pkg::*;
#(
  parameter int                WORD_W    = 8,
  parameter int                LEN_W     = 16,
  parameter int                CHAIN_LEN = CFG_CHAIN_LEN,
  parameter logic [WORD_W-1:0] SYNC_WORD = CFG_SYNC_WORD
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              cfg_bit,
  output logic              cen,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int               WB_W     = $clog2(WORD_W + 1);
  localparam logic [LEN_W-1:0] LEN_EXP  = LEN_W'(CHAIN_LEN);
  localparam logic [LEN_W-1:0] WORD_W_L = LEN_W'(WORD_W);

  cfg_state_e                r_state;
  cfg_state_e                w_state_nxt;
  logic [LEN_W-WORD_W-1:0]   r_len_hi;
  logic [LEN_W-1:0]          r_bits_left;
  logic [LEN_W-1:0]          w_len;
  logic [LEN_W-1:0]          w_last_ext;
  logic [LEN_W-1:0]          w_avail;
  logic [WB_W-1:0]           w_nbits;
  logic                      w_xfer;
  logic                      w_load;
  logic                      w_ser_empty;
  logic                      w_ser_last;

  assign w_xfer     = s_valid && s_ready;
  assign w_load     = w_xfer && (r_state == ST_SHIFT);
  assign w_len      = {r_len_hi, s_data};
  assign w_last_ext = {{(LEN_W-1){1'b0}}, w_ser_last};
  // Bits not yet loaded into the serializer; the bit shifting out this cycle is already accounted for
  assign w_avail    = r_bits_left - w_last_ext;
  // Padding above the end of the chain is never counted, so it is never shifted
  assign w_nbits    = (w_avail >= WORD_W_L) ? WB_W'(WORD_W) : w_avail[WB_W-1:0];

  cfg_word_serializer #(
    .WORD_W (WORD_W),
    .WB_W   (WB_W)
  ) u_ser (
    .cclk      (cclk),
    .rst       (rst),
    .i_load    (w_load),
    .i_word    (s_data),
    .i_nbits   (w_nbits),
    .o_cen     (cen),
    .o_cfg_bit (cfg_bit),
    .o_empty   (w_ser_empty),
    .o_last    (w_ser_last)
  );

  // State register
  always_ff @(posedge cclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: sync hunt, header capture, shifting and terminal states
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_xfer && (s_data == SYNC_WORD)) w_state_nxt = ST_HDR_HI;
      ST_HDR_HI: if (w_xfer) w_state_nxt = ST_HDR_LO;
      ST_HDR_LO: if (w_xfer) w_state_nxt = (w_len == LEN_EXP) ? ST_SHIFT : ST_ERR;
      ST_SHIFT:  if (cen && (r_bits_left == LEN_W'(1))) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      ST_ERR:    w_state_nxt = ST_ERR;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: handshake and status flags
  always_comb begin
    s_ready = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    case (r_state)
      ST_IDLE, ST_HDR_HI, ST_HDR_LO: s_ready = 1'b1;
      ST_SHIFT: s_ready = (w_ser_empty || w_ser_last) && (r_bits_left > w_last_ext);
      ST_DONE:  done    = 1'b1;
      ST_ERR:   error   = 1'b1;
      default:  s_ready = 1'b0;
    endcase
    busy = (r_state == ST_HDR_HI) || (r_state == ST_HDR_LO) || (r_state == ST_SHIFT);
  end

  // Length header capture and remaining-chain-bit counter
  always_ff @(posedge cclk) begin
    if (rst) begin
      r_len_hi    <= '0;
      r_bits_left <= '0;
    end else begin
      if ((r_state == ST_HDR_HI) && w_xfer) begin
        r_len_hi <= s_data[LEN_W-WORD_W-1:0];
      end
      if ((r_state == ST_HDR_LO) && w_xfer && (w_len == LEN_EXP)) begin
        r_bits_left <= LEN_EXP;
      end else if ((r_state == ST_SHIFT) && cen) begin
        r_bits_left <= r_bits_left - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clb_config_loader.sv
module tb_clb_config_loader;

  localparam int CHAIN = 139;

  logic       cclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready, cfg_bit, cen, busy, done, error;

  always #5 cclk = ~cclk;

  clb_config_loader dut (
    .cclk    (cclk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .cfg_bit (cfg_bit),
    .cen     (cen),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  int   checks = 0;
  int   errors = 0;
  bit   exp_q[$];
  bit   exp_b;
  int   cen_cnt = 0;
  int   run = 0;
  int   done_cnt = 0;
  bit   prev_cen = 1'b0;
  bit   prev_done = 1'b0;
  bit   gapfree = 1'b1;
  logic [7:0] pay [18];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops an expected chain bit for every cen, and audits each done pulse
  always @(negedge cclk) begin
    if (rst) begin
      cen_cnt   = 0;
      run       = 0;
      prev_cen  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("done_after_last_cen", prev_cen, 1);
        chk("done_busy_low", busy, 0);
        chk("frame_cen_count", cen_cnt, CHAIN);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_single_cycle", prev_done, 0);
        if (gapfree) chk("gapfree_run", run, CHAIN);
        cen_cnt = 0;
      end
      if (cen) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cen_unexpected bit=%0b idx=%0d required=no_cen", cfg_bit, cen_cnt);
        end else begin
          exp_b = exp_q.pop_front();
          if (cfg_bit !== exp_b) begin
            errors++;
            $display("FAIL cfg_bit idx=%0d actual=%0b required=%0b", cen_cnt, cfg_bit, exp_b);
          end
        end
        cen_cnt++;
        run++;
      end else begin
        run = 0;
      end
      prev_cen  = cen;
      prev_done = done;
    end
  end

  task automatic tick();
    @(negedge cclk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    int t;
    t = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && t < 400) begin
      tick();
      t++;
    end
    if (!s_ready) chk("send_timeout", s_ready, 1);
    tick();
  endtask

  task automatic push_word(input int i, inout int rem);
    int n;
    n = (rem < 8) ? rem : 8;
    for (int b = 0; b < n; b++) exp_q.push_back(pay[i][b]);
    rem -= n;
  endtask

  task automatic send_frame(input bit stall);
    int rem;
    send_word(8'hA5);
    chk("busy_after_sync", busy, 1);
    send_word(8'h00);
    send_word(8'h8B);
    chk("busy_in_shift", busy, 1);
    rem = CHAIN;
    for (int i = 0; i < 18; i++) begin
      push_word(i, rem);
      send_word(pay[i]);
      if (stall && i == 2) begin
        s_valid = 1'b0;
        repeat (8) tick();
        for (int k = 0; k < 5; k++) begin
          chk("stall_cen_low", cen, 0);
          tick();
        end
      end
    end
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 400) begin
      tick();
      t++;
    end
    chk("done_seen", done_cnt, target);
    if (done_cnt == target) chk("done_s_ready_low", s_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem;
    int t;
    pay = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h96,
            8'h69, 8'h0F, 8'hF0, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hF8};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_cen", cen, 0);
    chk("rst_cfg_bit", cfg_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;
    tick();

    // Clean frame, continuous valid
    gapfree = 1'b1;
    send_frame(1'b0);
    s_valid = 1'b0;
    wait_done(1);
    tick();
    chk("idle_after_done_ready", s_ready, 1);
    chk("idle_after_done_busy", busy, 0);
    chk("idle_after_done_done", done, 0);

    // Garbage ahead of the sync word
    send_word(8'h00);
    chk("garbage0_busy", busy, 0);
    send_word(8'hFF);
    send_word(8'h3C);
    chk("garbage_busy", busy, 0);
    chk("garbage_ready", s_ready, 1);
    send_frame(1'b0);
    s_valid = 1'b0;
    wait_done(2);
    tick();

    // Length mismatch
    send_word(8'hA5);
    send_word(8'h00);
    send_word(8'h8A);
    s_data = 8'hA5;
    chk("err_flag", error, 1);
    chk("err_ready", s_ready, 0);
    chk("err_cen", cen, 0);
    chk("err_busy", busy, 0);
    repeat (4) tick();
    chk("err_flag_hold", error, 1);
    chk("err_ready_hold", s_ready, 0);
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("err_cleared", error, 0);
    chk("err_rst_ready", s_ready, 1);
    rst = 1'b0;
    tick();

    // Stall after payload word 3
    gapfree = 1'b0;
    send_frame(1'b1);
    s_valid = 1'b0;
    wait_done(3);
    gapfree = 1'b1;
    tick();

    // Reset after 60 chain bits
    send_word(8'hA5);
    send_word(8'h00);
    send_word(8'h8B);
    rem = CHAIN;
    for (int i = 0; i < 8; i++) begin
      push_word(i, rem);
      send_word(pay[i]);
    end
    s_valid = 1'b0;
    t = 0;
    while (cen_cnt < 60 && t < 200) begin
      tick();
      t++;
    end
    chk("pre_reset_cen_count", cen_cnt, 60);
    rst = 1'b1;
    tick();
    chk("midrst_cen", cen, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", s_ready, 1);
    chk("midrst_error", error, 0);
    exp_q.delete();
    rst = 1'b0;
    tick();
    send_frame(1'b0);
    s_valid = 1'b0;
    wait_done(4);
    tick();

    // Back-to-back frames: second sync waits in line while the first finishes
    send_frame(1'b0);
    send_frame(1'b0);
    s_valid = 1'b0;
    wait_done(6);
    repeat (3) tick();
    chk("final_idle_ready", s_ready, 1);
    chk("final_no_error", error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
